// File: rtl/trax_pkg.sv
// Shared Trax encodings: tile types, sides, response codes and edge-colour helpers.
package trax_pkg;

  localparam logic [1:0] TILE_EMPTY  = 2'b00;
  localparam logic [1:0] TILE_PLUS   = 2'b01;
  localparam logic [1:0] TILE_SLASH  = 2'b10;
  localparam logic [1:0] TILE_BSLASH = 2'b11;

  localparam logic [1:0] SIDE_UP    = 2'd0;
  localparam logic [1:0] SIDE_DOWN  = 2'd1;
  localparam logic [1:0] SIDE_LEFT  = 2'd2;
  localparam logic [1:0] SIDE_RIGHT = 2'd3;

  localparam logic [2:0] RSP_OK       = 3'd0;
  localparam logic [2:0] RSP_RANGE    = 3'd1;
  localparam logic [2:0] RSP_OCCUPIED = 3'd2;
  localparam logic [2:0] RSP_ISOLATED = 3'd3;
  localparam logic [2:0] RSP_FULL     = 3'd4;
  localparam logic [2:0] RSP_BADTYPE  = 3'd5;
  localparam logic [2:0] RSP_MISMATCH = 3'd6;

  typedef struct packed {
    logic [1:0] tileType;
    logic       colour;
  } cell_t;

  // An edge shows either the top colour c or its inverse; this says which.
  function automatic logic edgeInvert(input logic [1:0] tileType, input logic [1:0] side);
    logic inv;
    inv = 1'b0;
    case (tileType)
      TILE_PLUS:   inv = (side == SIDE_LEFT) || (side == SIDE_RIGHT);
      TILE_SLASH:  inv = (side == SIDE_DOWN) || (side == SIDE_RIGHT);
      TILE_BSLASH: inv = (side == SIDE_DOWN) || (side == SIDE_LEFT);
      default:     inv = 1'b0;
    endcase
    return inv;
  endfunction

  function automatic logic edgeColour(input logic [1:0] tileType, input logic colour,
                                      input logic [1:0] side);
    return colour ^ edgeInvert(tileType, side);
  endfunction

  function automatic logic [1:0] oppositeSide(input logic [1:0] side);
    return side ^ 2'b01;
  endfunction

endpackage

// File: rtl/trax_edge_color.sv
// Combinational: reads the neighbour's shared edge and solves the new tile's top colour c.
module trax_edge_color
  import trax_pkg::*;
(
  input  logic [1:0] nb_type_i,
  input  logic       nb_colour_i,
  input  logic [1:0] side_i,
  input  logic [1:0] new_type_i,
  output logic       colour_o
);

  logic nbEdge;

  // side_i is the side of the new tile that faces the neighbour.
  assign nbEdge   = edgeColour(nb_type_i, nb_colour_i, oppositeSide(side_i));
  assign colour_o = nbEdge ^ edgeInvert(new_type_i, side_i);

endmodule

// File: rtl/trax_board_grid.sv
// Trax board store with neighbour-derived colour and down/right board shifting.
// Define TRAX_COLOR_CHECK_EN to reject placements whose neighbours disagree on colour.
module trax_board_grid
  import trax_pkg::*;
#(
  parameter int MAX_ROW = 20,
  parameter int MAX_COL = 20,
  parameter int IDX_W   = 10,
  parameter int MOVE_W  = 2*IDX_W+2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [MOVE_W-1:0] cmd_move,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [2:0]        rsp_code,
  output logic [IDX_W-1:0]  n_rows,
  output logic [IDX_W-1:0]  n_cols,
  input  logic [IDX_W-1:0]  rd_row,
  input  logic [IDX_W-1:0]  rd_col,
  output logic [2:0]        rd_cell,
  output logic [15:0]       tile_count,
  output logic              busy
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CHECK   = 3'd1;
  localparam logic [2:0] ST_SHIFT_D = 3'd2;
  localparam logic [2:0] ST_SHIFT_R = 3'd3;
  localparam logic [2:0] ST_WRITE   = 3'd4;
  localparam logic [2:0] ST_RESP    = 3'd5;

  localparam logic [IDX_W-1:0] IDX_ZERO  = '0;
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);
  localparam logic [IDX_W-1:0] ROW_LIMIT = IDX_W'(MAX_ROW);
  localparam logic [IDX_W-1:0] COL_LIMIT = IDX_W'(MAX_COL);

  logic [2:0]       state_q, state_d;
  cell_t            cells_q [MAX_ROW][MAX_COL];
  cell_t            cells_d [MAX_ROW][MAX_COL];
  logic [IDX_W-1:0] nRows_q, nRows_d;
  logic [IDX_W-1:0] nCols_q, nCols_d;
  logic [IDX_W-1:0] moveRow_q, moveRow_d;
  logic [IDX_W-1:0] moveCol_q, moveCol_d;
  logic [IDX_W-1:0] shiftCnt_q, shiftCnt_d;
  logic [1:0]       moveType_q, moveType_d;
  logic             colour_q, colour_d;
  logic             rspErr_q, rspErr_d;
  logic [2:0]       rspCode_q, rspCode_d;
  logic [15:0]      tileCount_q, tileCount_d;

  cell_t            nbCell [4];
  cell_t            targetCell;
  logic [3:0]       nbOcc;
  logic [3:0]       nbColour;
  logic             derivedColour;
  logic [2:0]       checkCode;
  logic [IDX_W-1:0] rowLast, colLast;
  logic [IDX_W-1:0] physRow, physCol;
  logic             rowGrow, colGrow;

  // Cells addressed in extended coordinates; margins and beyond read as empty.
  function automatic cell_t readExt(input logic [IDX_W-1:0] er, input logic [IDX_W-1:0] ec);
    cell_t val;
    val = '0;
    for (int i = 0; i < MAX_ROW; i++) begin
      for (int j = 0; j < MAX_COL; j++) begin
        if (er == IDX_W'(i + 1) && ec == IDX_W'(j + 1)) val = cells_q[i][j];
      end
    end
    return val;
  endfunction

  always_comb begin
    rowLast    = nRows_q + IDX_ONE;
    colLast    = nCols_q + IDX_ONE;
    nbCell[0]  = readExt(moveRow_q - IDX_ONE, moveCol_q);
    nbCell[1]  = readExt(moveRow_q + IDX_ONE, moveCol_q);
    nbCell[2]  = readExt(moveRow_q, moveCol_q - IDX_ONE);
    nbCell[3]  = readExt(moveRow_q, moveCol_q + IDX_ONE);
    targetCell = readExt(moveRow_q, moveCol_q);
    for (int s = 0; s < 4; s++) nbOcc[s] = (nbCell[s].tileType != TILE_EMPTY);
    physRow    = (moveRow_q == IDX_ZERO) ? IDX_ZERO : moveRow_q - IDX_ONE;
    physCol    = (moveCol_q == IDX_ZERO) ? IDX_ZERO : moveCol_q - IDX_ONE;
    rowGrow    = (moveRow_q == IDX_ZERO) || (moveRow_q == rowLast);
    colGrow    = (moveCol_q == IDX_ZERO) || (moveCol_q == colLast);
  end

  for (genvar s = 0; s < 4; s++) begin : g_nb
    trax_edge_color u_edge (
      .nb_type_i   (nbCell[s].tileType),
      .nb_colour_i (nbCell[s].colour),
      .side_i      (2'(s)),
      .new_type_i  (moveType_q),
      .colour_o    (nbColour[s])
    );
  end

  // First occupied neighbour in up, down, left, right order decides the colour.
  always_comb begin
    derivedColour = 1'b0;
    if (nbOcc[0])      derivedColour = nbColour[0];
    else if (nbOcc[1]) derivedColour = nbColour[1];
    else if (nbOcc[2]) derivedColour = nbColour[2];
    else if (nbOcc[3]) derivedColour = nbColour[3];
  end

`ifdef TRAX_COLOR_CHECK_EN
  logic colourConflict;
  assign colourConflict = |(nbOcc & (nbColour ^ {4{derivedColour}}));
`endif

  always_comb begin
    checkCode = RSP_OK;
    if (moveType_q == TILE_EMPTY) begin
      checkCode = RSP_BADTYPE;
    end else if (nRows_q == IDX_ZERO) begin
      checkCode = RSP_OK;
    end else if (moveRow_q > rowLast || moveCol_q > colLast) begin
      checkCode = RSP_RANGE;
    end else if ((rowGrow && nRows_q == ROW_LIMIT) || (colGrow && nCols_q == COL_LIMIT)) begin
      checkCode = RSP_FULL;
    end else if (targetCell.tileType != TILE_EMPTY) begin
      checkCode = RSP_OCCUPIED;
    end else if (nbOcc == 4'b0000) begin
      checkCode = RSP_ISOLATED;
`ifdef TRAX_COLOR_CHECK_EN
    end else if (colourConflict) begin
      checkCode = RSP_MISMATCH;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    cells_d     = cells_q;
    nRows_d     = nRows_q;
    nCols_d     = nCols_q;
    moveRow_d   = moveRow_q;
    moveCol_d   = moveCol_q;
    shiftCnt_d  = shiftCnt_q;
    moveType_d  = moveType_q;
    colour_d    = colour_q;
    rspErr_d    = rspErr_q;
    rspCode_d   = rspCode_q;
    tileCount_d = tileCount_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          moveType_d = cmd_move[MOVE_W-1 -: 2];
          moveCol_d  = cmd_move[2*IDX_W-1:IDX_W];
          moveRow_d  = cmd_move[IDX_W-1:0];
          state_d    = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (checkCode != RSP_OK) begin
          rspErr_d  = 1'b1;
          rspCode_d = checkCode;
          state_d   = ST_RESP;
        end else if (nRows_q == IDX_ZERO) begin
          // First tile: pretend it lands at extended (1,1) so WRITE grows n and m.
          moveRow_d = IDX_ONE;
          moveCol_d = IDX_ONE;
          colour_d  = 1'b0;
          state_d   = ST_WRITE;
        end else begin
          colour_d = derivedColour;
          if (moveRow_q == IDX_ZERO) begin
            shiftCnt_d = nRows_q - IDX_ONE;
            state_d    = ST_SHIFT_D;
          end else if (moveCol_q == IDX_ZERO) begin
            shiftCnt_d = nCols_q - IDX_ONE;
            state_d    = ST_SHIFT_R;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_SHIFT_D: begin
        for (int i = 1; i < MAX_ROW; i++) begin
          if (IDX_W'(i - 1) == shiftCnt_q) begin
            for (int j = 0; j < MAX_COL; j++) cells_d[i][j] = cells_q[i-1][j];
          end
        end
        if (shiftCnt_q == IDX_ZERO) begin
          for (int j = 0; j < MAX_COL; j++) cells_d[0][j] = '0;
          nRows_d = rowLast;
          if (moveCol_q == IDX_ZERO) begin
            shiftCnt_d = nCols_q - IDX_ONE;
            state_d    = ST_SHIFT_R;
          end else begin
            state_d = ST_WRITE;
          end
        end else begin
          shiftCnt_d = shiftCnt_q - IDX_ONE;
        end
      end
      ST_SHIFT_R: begin
        for (int j = 1; j < MAX_COL; j++) begin
          if (IDX_W'(j - 1) == shiftCnt_q) begin
            for (int i = 0; i < MAX_ROW; i++) cells_d[i][j] = cells_q[i][j-1];
          end
        end
        if (shiftCnt_q == IDX_ZERO) begin
          for (int i = 0; i < MAX_ROW; i++) cells_d[i][0] = '0;
          nCols_d = colLast;
          state_d = ST_WRITE;
        end else begin
          shiftCnt_d = shiftCnt_q - IDX_ONE;
        end
      end
      ST_WRITE: begin
        for (int i = 0; i < MAX_ROW; i++) begin
          for (int j = 0; j < MAX_COL; j++) begin
            if (physRow == IDX_W'(i) && physCol == IDX_W'(j)) begin
              cells_d[i][j].tileType = moveType_q;
              cells_d[i][j].colour   = colour_q;
            end
          end
        end
        if (moveRow_q == rowLast) nRows_d = rowLast;
        if (moveCol_q == colLast) nCols_d = colLast;
        tileCount_d = tileCount_q + 16'd1;
        rspErr_d    = 1'b0;
        rspCode_d   = RSP_OK;
        state_d     = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Reset also abandons any half-finished shift without responding.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      nRows_q     <= '0;
      nCols_q     <= '0;
      moveRow_q   <= '0;
      moveCol_q   <= '0;
      shiftCnt_q  <= '0;
      moveType_q  <= '0;
      colour_q    <= 1'b0;
      rspErr_q    <= 1'b0;
      rspCode_q   <= RSP_OK;
      tileCount_q <= '0;
      for (int i = 0; i < MAX_ROW; i++) begin
        for (int j = 0; j < MAX_COL; j++) cells_q[i][j] <= '0;
      end
    end else begin
      state_q     <= state_d;
      nRows_q     <= nRows_d;
      nCols_q     <= nCols_d;
      moveRow_q   <= moveRow_d;
      moveCol_q   <= moveCol_d;
      shiftCnt_q  <= shiftCnt_d;
      moveType_q  <= moveType_d;
      colour_q    <= colour_d;
      rspErr_q    <= rspErr_d;
      rspCode_q   <= rspCode_d;
      tileCount_q <= tileCount_d;
      cells_q     <= cells_d;
    end
  end

  always_comb begin
    rd_cell = 3'b000;
    for (int i = 0; i < MAX_ROW; i++) begin
      for (int j = 0; j < MAX_COL; j++) begin
        if (rd_row == IDX_W'(i) && rd_col == IDX_W'(j)) rd_cell = cells_q[i][j];
      end
    end
  end

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_err    = rspErr_q;
  assign rsp_code   = rspCode_q;
  assign n_rows     = nRows_q;
  assign n_cols     = nCols_q;
  assign tile_count = tileCount_q;

endmodule
